branch_resolve_ctrl: RTL
========================

Name: branch_resolve_ctrl

Overview:
- ID-stage branch resolution controller for the 5-stage MIPS pipeline.
- Sequences the 32-bit equality comparator for beq/bne. Detects RAW hazards on the branch operands against EX and MEM, and stalls IF/ID for the required cycles.
- Selects forwarded operands, then issues the taken/flush decision.
- Also keeps branch performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- REG_W, 5, register-specifier width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_is_beq  in  1  instruction in ID is beq.
- id_is_bne  in  1  instruction in ID is bne.
- id_rs  in  REG_W  rs specifier of the ID instruction.
- id_rt  in  REG_W  rt specifier of the ID instruction.
- id_rs_data  in  32  register-file read port A (write-before-read register file).
- id_rt_data  in  32  register-file read port B.
- ex_regwrite  in  1  ID/EX writes a register.
- ex_memread  in  1  ID/EX is a load.
- ex_rd  in  REG_W  ID/EX destination register.
- mem_regwrite  in  1  EX/MEM writes a register.
- mem_memread  in  1  EX/MEM is a load.
- mem_rd  in  REG_W  EX/MEM destination register.
- mem_fwd_data  in  32  EX/MEM ALU result.
- id_flush  in  1  external squash of the ID instruction.
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- taken  out  1  branch taken; PC takes the branch target.
- if_flush  out  1  squash the IF/ID register.
- br_cnt  out  CNT_W  resolved branches.
- taken_cnt  out  CNT_W  taken branches.
- stall_cnt  out  CNT_W  branch stall cycles.

Behaviour:
- is_br = id_valid & (id_is_beq | id_is_bne) & ~id_flush.
- Hazard on source s (s != 0), giving stall need N:
  - ex_memread & ex_rd==s gives N=2.
  - Otherwise ex_regwrite & ex_rd==s gives N=1.
  - Otherwise mem_memread & mem_rd==s gives N=1.
  - Otherwise N=0.
  - N is the maximum over rs and rt.
- Operand select, per source: use mem_fwd_data when mem_regwrite & ~mem_memread & mem_rd==s & s!=0; otherwise use the register-file data.
- eq = (opA == opB), full 32-bit compare. Compare against register 0 always uses 0 from the register file.
- taken_raw = (id_is_beq & eq) | (id_is_bne & ~eq).
- FSM states: IDLE, WAIT, RESOLVE. Counter cnt is 2 bits.
- IDLE:
  - is_br & N==0: taken = if_flush = taken_raw in the same cycle; stay in IDLE.
  - is_br & N>0: stall=1, cnt <= N-1, next state is RESOLVE if N==1, else WAIT.
- WAIT: stall=1, cnt <= cnt-1; go to RESOLVE when cnt==1.
- RESOLVE: stall=0; evaluate with forwarding; taken = if_flush = taken_raw; go to IDLE.
- Total stall cycles equal N exactly.
- stall, taken and if_flush are combinational from state plus inputs. They are 0 outside the conditions above.
- id_flush in WAIT or RESOLVE: go to IDLE immediately, force stall=taken=if_flush=0, no counter update.
- id_flush in IDLE: the branch is ignored.
- Counters:
  - br_cnt increments on each resolution cycle.
  - taken_cnt increments when taken=1.
  - stall_cnt increments on each stall=1 cycle.
  - All counters wrap modulo 2^CNT_W.
- rst, including mid-operation: state=IDLE, cnt=0, all counters 0. stall, taken and if_flush are 0 during the rst cycle.
- Non-branch instructions in ID: outputs 0, state unchanged.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, WAIT=1, RESOLVE=2).
  - ZERO_REG constant.
  - Stall-need constants.
- Sub-module: branch_equ_cmp, a 32-bit equality comparator with two operands in and a 1-bit out. It is instantiated once on the forwarded operands.

Test Plan:
- beq r1,r2 with no hazards, 5==5 -> same cycle taken=1, if_flush=1, stall=0; br_cnt=1, taken_cnt=1.
- bne r3,r4, ex_regwrite with ex_rd=3 -> 1 stall cycle, then RESOLVE with mem_rd=3, mem_fwd_data=7, rt=7 -> taken=0; stall_cnt=1.
- beq r5,r0 with ex_memread and ex_rd=5 -> stall for 2 cycles (WAIT then RESOLVE); reg file returns 0 -> taken=1; stall_cnt=2.
- Load in MEM (mem_memread, mem_rd=6) on beq r6,r6 -> 1 stall, then taken=1.
- Branch with rs=rt=0 and ex_rd=0, ex_regwrite=1 -> no stall, taken=1 for beq.
- id_flush asserted in WAIT -> next cycle IDLE, taken=0, br_cnt unchanged.
- rst pulsed in WAIT -> all outputs 0, counters 0; the following branch resolves normally.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared types and constants for the ID-stage branch resolution controller.
package branch_resolve_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  localparam int unsigned ZERO_REG = 0;

  // Number of stall cycles a branch operand still needs before it is usable.
  localparam logic [1:0] NEED_NONE = 2'd0;
  localparam logic [1:0] NEED_ONE  = 2'd1;
  localparam logic [1:0] NEED_TWO  = 2'd2;

  function automatic logic [1:0] max_need(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Pipeline-side bundle for the branch resolution controller: ID operands,
// EX/MEM hazard info, and the stall/taken/flush decisions plus counters.
interface branch_resolve_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
);
  logic             id_valid;
  logic             id_is_beq;
  logic             id_is_bne;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [31:0]      id_rs_data;
  logic [31:0]      id_rt_data;
  logic             ex_regwrite;
  logic             ex_memread;
  logic [REG_W-1:0] ex_rd;
  logic             mem_regwrite;
  logic             mem_memread;
  logic [REG_W-1:0] mem_rd;
  logic [31:0]      mem_fwd_data;
  logic             id_flush;
  logic             stall;
  logic             taken;
  logic             if_flush;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: presents the ID instruction and hazard context.
  modport master (
    output id_valid, id_is_beq, id_is_bne, id_rs, id_rt, id_rs_data, id_rt_data,
    output ex_regwrite, ex_memread, ex_rd,
    output mem_regwrite, mem_memread, mem_rd, mem_fwd_data, id_flush,
    input  stall, taken, if_flush, br_cnt, taken_cnt, stall_cnt
  );

  // Controller side.
  modport slave (
    input  id_valid, id_is_beq, id_is_bne, id_rs, id_rt, id_rs_data, id_rt_data,
    input  ex_regwrite, ex_memread, ex_rd,
    input  mem_regwrite, mem_memread, mem_rd, mem_fwd_data, id_flush,
    output stall, taken, if_flush, br_cnt, taken_cnt, stall_cnt
  );
endinterface

// File: rtl/branch_equ_cmp.sv
// 32-bit equality comparator used on the forwarded branch operands.
module branch_equ_cmp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eq
);
  // Full-width compare.
  always_comb eq = (a == b);
endmodule

// File: rtl/branch_resolve_ctrl.sv
// ID-stage beq/bne resolution: detects RAW hazards against EX/MEM, stalls
// for exactly the needed cycles, forwards the MEM ALU result, and issues
// taken/if_flush. Also counts resolved branches, taken branches and stalls.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input logic                  clk,
  input logic                  rst,
  branch_resolve_ctrl_if.slave bus
);

  localparam logic [REG_W-1:0] ZERO_SPEC = REG_W'(ZERO_REG);

  state_t           state;
  logic [1:0]       cnt;
  logic [1:0]       need_rs, need_rt, need;
  logic             is_br;
  logic             fwd_rs, fwd_rt;
  logic [31:0]      op_a, op_b;
  logic             eq;
  logic             taken_raw;
  logic             stall_c, resolve_c, taken_c;
  logic [CNT_W-1:0] br_cnt_q, taken_cnt_q, stall_cnt_q;

  function automatic logic [1:0] hazard_need(
    input logic [REG_W-1:0] s,
    input logic             ex_rw,
    input logic             ex_mr,
    input logic [REG_W-1:0] ex_rd,
    input logic             mem_mr,
    input logic [REG_W-1:0] mem_rd
  );
    logic [1:0] n;
    n = NEED_NONE;
    if (s != ZERO_SPEC) begin
      if (ex_mr && ex_rd == s)        n = NEED_TWO;
      else if (ex_rw && ex_rd == s)   n = NEED_ONE;
      else if (mem_mr && mem_rd == s) n = NEED_ONE;
    end
    return n;
  endfunction

  // Branch detection, stall need and forwarded operand selection.
  always_comb begin
    is_br   = bus.id_valid & (bus.id_is_beq | bus.id_is_bne) & ~bus.id_flush;
    need_rs = hazard_need(bus.id_rs, bus.ex_regwrite, bus.ex_memread, bus.ex_rd,
                          bus.mem_memread, bus.mem_rd);
    need_rt = hazard_need(bus.id_rt, bus.ex_regwrite, bus.ex_memread, bus.ex_rd,
                          bus.mem_memread, bus.mem_rd);
    need    = max_need(need_rs, need_rt);
    fwd_rs  = bus.mem_regwrite & ~bus.mem_memread &
              (bus.mem_rd == bus.id_rs) & (bus.id_rs != ZERO_SPEC);
    fwd_rt  = bus.mem_regwrite & ~bus.mem_memread &
              (bus.mem_rd == bus.id_rt) & (bus.id_rt != ZERO_SPEC);
    op_a    = fwd_rs ? bus.mem_fwd_data : bus.id_rs_data;
    op_b    = fwd_rt ? bus.mem_fwd_data : bus.id_rt_data;
  end

  branch_equ_cmp u_cmp (
    .a  (op_a),
    .b  (op_b),
    .eq (eq)
  );

  // Decision outputs, combinational from state and the current ID/EX/MEM view.
  always_comb begin
    stall_c   = 1'b0;
    resolve_c = 1'b0;
    taken_raw = (bus.id_is_beq & eq) | (bus.id_is_bne & ~eq);
    if (!rst) begin
      case (state)
        IDLE: begin
          if (is_br) begin
            if (need == NEED_NONE) resolve_c = 1'b1;
            else                   stall_c   = 1'b1;
          end
        end
        WAIT:    stall_c   = ~bus.id_flush;
        RESOLVE: resolve_c = ~bus.id_flush;
        default: ;
      endcase
    end
    taken_c = resolve_c & taken_raw;
  end

  assign bus.stall     = stall_c;
  assign bus.taken     = taken_c;
  assign bus.if_flush  = taken_c;
  assign bus.br_cnt    = br_cnt_q;
  assign bus.taken_cnt = taken_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;

  // Stall sequencing FSM and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_br && need != NEED_NONE) begin
            cnt   <= need - 2'd1;
            state <= (need == NEED_ONE) ? RESOLVE : WAIT;
          end
        end
        WAIT: begin
          if (bus.id_flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 2'd1;
            if (cnt == 2'd1) state <= RESOLVE;
          end
        end
        RESOLVE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (resolve_c) br_cnt_q    <= br_cnt_q + CNT_W'(1);
      if (taken_c)   taken_cnt_q <= taken_cnt_q + CNT_W'(1);
      if (stall_c)   stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

endmodule
